mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between instruction fetch (IF) and the load/store path (LS).

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync memory between IF and LS; define ARB_RR_EN for round-robin arbitration
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic                  ls_wen,
  input  logic [DATA_W/8-1:0]   ls_wmask,
  input  logic [DATA_W-1:0]     ls_wdata,
  output logic                  ls_rsp_valid,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  mem_en,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_wmask,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT must be 1..4");
  end

  logic [1:0]          state;
  logic [2:0]          cnt;
  logic                gnt_ls;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                idle, issue, resp, hs, sel_ls;

  assign idle  = state == IDLE;
  assign issue = state == ISSUE;
  assign resp  = state == RESP;
  assign hs    = idle && (if_req_valid || ls_req_valid);

`ifdef ARB_RR_EN
  logic last_ls;
  assign sel_ls = ls_req_valid && (!if_req_valid || !last_ls);
  // remember who won the last handshake so a tie goes to the other side
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_ls <= 1'b0;
    else if (hs) last_ls <= sel_ls;
`else
  assign sel_ls = ls_req_valid;
`endif

  assign ls_req_ready = idle && sel_ls;
  assign if_req_ready = idle && !sel_ls && if_req_valid;

  // transaction sequencing; request fields are captured once at the handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      gnt_ls  <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          state   <= ISSUE;
          gnt_ls  <= sel_ls;
          addr_q  <= sel_ls ? ls_addr : if_addr;
          wen_q   <= sel_ls && ls_wen;
          wmask_q <= (sel_ls && ls_wen) ? ls_wmask : '0;
          wdata_q <= sel_ls ? ls_wdata : '0;
        end
        ISSUE: begin
          state <= (MEM_LAT == 1) ? RESP : WAIT;
          cnt   <= 3'(MEM_LAT - 1);
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_en       = issue;
  assign mem_wen      = issue && wen_q;
  assign mem_addr     = issue ? addr_q : '0;
  assign mem_wmask    = issue ? wmask_q : '0;
  assign mem_wdata    = issue ? wdata_q : '0;
  assign if_rsp_valid = resp && !gnt_ls;
  assign ls_rsp_valid = resp && gnt_ls;
  assign if_rdata     = if_rsp_valid ? mem_rdata : '0;
  assign ls_rdata     = (ls_rsp_valid && !wen_q) ? mem_rdata : '0;
  assign busy         = !idle;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a latency-accurate memory model
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr = '0, if_rdata;
  logic        ls_req_valid = 1'b0, ls_req_ready, ls_wen = 1'b0, ls_rsp_valid;
  logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rdata;
  logic [3:0]  ls_wmask = '0;
  logic        mem_en, mem_wen, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wmask(ls_wmask), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit ls; logic [31:0] data; int at; } rsp_t;
  typedef struct { bit wen; logic [31:0] addr; logic [3:0] wm; logic [31:0] wd; int at; } mem_t;
  rsp_t rq[$];
  mem_t mq[$];
  bit   gnt_log[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] pipe [MEM_LAT];

  always @(posedge clk) begin
    if (mem_en && mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    pipe[0] <= (mem_en && !mem_wen) ? mem[mem_addr[5:2]] : 32'h0;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  always @(negedge clk) begin : monitor
    mem_t m;
    rsp_t r;
    if (rst) begin
      if (mem_en) begin
        if (mq.size() == 0) chk("mem_en_unexpected", 1, 0);
        else begin
          m = mq.pop_front();
          chk("mem_cycle", cyc, m.at);
          chk("mem_wen", mem_wen, m.wen);
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_wmask", mem_wmask, m.wm);
          if (m.wen) chk("mem_wdata", mem_wdata, m.wd);
          chk("busy_issue", busy, 1);
        end
      end
      if (if_rsp_valid || ls_rsp_valid) begin
        chk("rsp_both", if_rsp_valid && ls_rsp_valid, 0);
        if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          chk("rsp_cycle", cyc, r.at);
          chk("rsp_port_ls", ls_rsp_valid, r.ls);
          chk("rsp_data", r.ls ? ls_rdata : if_rdata, r.data);
          chk("rsp_other_rdata", r.ls ? if_rdata : ls_rdata, 0);
        end
      end
    end
  end

  task automatic send(input bit ls, input bit wen, input logic [31:0] addr,
                      input logic [3:0] wm, input logic [31:0] wd, output int hs);
    mem_t m;
    rsp_t r;
    bit done = 0;
    hs = -1;
    if (ls) begin
      ls_req_valid = 1; ls_addr = addr; ls_wen = wen; ls_wmask = wm; ls_wdata = wd;
    end else begin
      if_req_valid = 1; if_addr = addr;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ls ? ls_req_ready : if_req_ready) begin
        done = 1;
        hs = cyc;
        chk("busy_at_hs", busy, 0);
        m.wen = wen; m.addr = addr; m.wm = wen ? wm : 4'h0; m.wd = wd; m.at = cyc + 1;
        mq.push_back(m);
        r.ls = ls; r.data = wen ? 32'h0 : ref_mem[addr[5:2]]; r.at = cyc + 1 + MEM_LAT;
        rq.push_back(r);
        if (ls && wen)
          for (int b = 0; b < 4; b++)
            if (wm[b]) ref_mem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];
        gnt_log.push_back(ls);
      end
    end
    if (!done) chk(ls ? "ls_hs_timeout" : "if_hs_timeout", 0, 1);
    @(posedge clk); #1;
    if (ls) ls_req_valid = 0; else if_req_valid = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    rq.delete(); mq.delete(); gnt_log.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int h_ls, h_if, h;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h1000_0000 + 32'h0101_0101 * i;
      ref_mem[i] = 32'h1000_0000 + 32'h0101_0101 * i;
    end
    mem[0] = 32'h0000_0413;
    ref_mem[0] = 32'h0000_0413;
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_rsp", if_rsp_valid, 0);
    chk("rst_ls_rsp", ls_rsp_valid, 0);
    @(posedge clk); #1 rst = 1;

    // IF fetch
    send(0, 0, 32'h8000_0000, 4'h0, 32'h0, h);
    idle_cycles(MEM_LAT + 3);
    chk("if_fetch_data_model", ref_mem[0], 32'h0000_0413);

    // partial store, masked-off store, load back
    send(1, 1, 32'h8000_1004, 4'b0011, 32'hdead_beef, h);
    idle_cycles(MEM_LAT + 3);
    send(1, 1, 32'h8000_1008, 4'b0000, 32'h1234_5678, h);
    idle_cycles(MEM_LAT + 3);
    chk("store_merge_model", ref_mem[1], 32'h1101_beef);
    send(1, 0, 32'h8000_1004, 4'h0, 32'h0, h);
    idle_cycles(MEM_LAT + 3);
    send(1, 0, 32'h8000_1008, 4'h0, 32'h0, h);
    idle_cycles(MEM_LAT + 3);

    // simultaneous requests straight after reset: LS first, IF after one full transaction
    do_reset();
    fork
      send(1, 0, 32'h8000_0008, 4'h0, 32'h0, h_ls);
      send(0, 0, 32'h8000_0010, 4'h0, 32'h0, h_if);
      begin
        @(negedge clk);
        chk("tie_ls_ready", ls_req_ready, 1);
        chk("tie_if_ready", if_req_ready, 0);
      end
    join
    chk("if_accept_delay", h_if - h_ls, MEM_LAT + 2);
    idle_cycles(MEM_LAT + 3);

    // both sides keep requesting for four transactions
    do_reset();
    fork
      begin
        send(1, 0, 32'h8000_0008, 4'h0, 32'h0, h);
        send(1, 0, 32'h8000_000c, 4'h0, 32'h0, h);
      end
      begin
        send(0, 0, 32'h8000_0010, 4'h0, 32'h0, h);
        send(0, 0, 32'h8000_0014, 4'h0, 32'h0, h);
      end
    join
    idle_cycles(MEM_LAT + 3);
    chk("grant_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
`ifdef ARB_RR_EN
      chk("grant_order", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 4'b1010);
`else
      chk("grant_order", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 4'b1100);
`endif
    end

    // reset during WAIT abandons the transaction
    send(0, 0, 32'h8000_0018, 4'h0, 32'h0, h);
    @(posedge clk); #1;
    chk("wait_busy", busy, 1);
    chk("wait_mem_en", mem_en, 0);
    #2 rst = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mem_en", mem_en, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_if_rsp", if_rsp_valid, 0);
    chk("arst_if_rdata", if_rdata, 0);
    chk("arst_ls_rsp", ls_rsp_valid, 0);
    rq.delete(); mq.delete();
    idle_cycles(2);
    rst = 1;
    idle_cycles(MEM_LAT + 3);
    send(0, 0, 32'h8000_001c, 4'h0, 32'h0, h);
    idle_cycles(MEM_LAT + 3);

    // IF valid pulse while LS is in flight must be ignored
    send(1, 1, 32'h8000_0020, 4'b1111, 32'hcafe_f00d, h);
    if_req_valid = 1; if_addr = 32'h8000_0024;
    @(negedge clk);
    chk("busy_if_ready", if_req_ready, 0);
    @(posedge clk); #1 if_req_valid = 0;
    idle_cycles(MEM_LAT + 4);
    chk("dropped_if_no_rsp", rq.size(), 0);
    send(1, 0, 32'h8000_0020, 4'h0, 32'h0, h);
    idle_cycles(MEM_LAT + 3);

    chk("rsp_queue_empty", rq.size(), 0);
    chk("mem_queue_empty", mq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
